// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared state type and constants for the UART command sequencer
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARG      = 3'd1,
        ST_DISPATCH = 3'd2,
        ST_WAIT     = 3'd3,
        ST_ECHO     = 3'd4,
        ST_SEND     = 3'd5,
        ST_NAK      = 3'd6
    } uart_cmd_state_t;

    localparam int         ARG_BYTES        = 4;
    localparam logic [7:0] NAK_BYTE_DEFAULT = 8'hEE;

endpackage

// File: rtl/uart_word_ser.sv
// rtl/uart_word_ser.sv - 32-bit word to 4-byte little-endian stream serializer
module uart_word_ser
    import uart_cmd_pkg::*;
(
    input  logic        clk,
    input  logic        Rst,
    input  logic        load_i,
    input  logic [31:0] word_i,
    input  logic        tready_i,
    output logic [7:0]  tdata_o,
    output logic        tvalid_o,
    output logic        tlast_o
);

    logic [31:0] word_q;
    logic [1:0]  idx_q;
    logic        active_q;

    // A load restarts the word even on the cycle the previous word finishes,
    // so consecutive words stream without a bubble.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            word_q   <= 32'd0;
            idx_q    <= 2'd0;
            active_q <= 1'b0;
        end else if (load_i) begin
            word_q   <= word_i;
            idx_q    <= 2'd0;
            active_q <= 1'b1;
        end else if (active_q && tready_i) begin
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'(ARG_BYTES - 1)) begin
                active_q <= 1'b0;
            end
        end
    end

    // Data is forced to zero while idle so the shared tx bus reads 0 outside a transfer.
    always_comb begin
        tvalid_o = active_q;
        tlast_o  = active_q && (idx_q == 2'(ARG_BYTES - 1));
        tdata_o  = active_q ? word_q[{idx_q, 3'b000} +: 8] : 8'h00;
    end

endmodule

// File: rtl/uart_cmd_seq.sv
// rtl/uart_cmd_seq.sv - UART command sequencer; echo of the argument enabled by UART_CMD_ECHO_EN
module uart_cmd_seq
    import uart_cmd_pkg::*;
#(
    parameter int         NUM_OPS        = 2,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] NAK_BYTE       = NAK_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  cmd_op,
    output logic [31:0] cmd_arg,
    output logic        cmd_start,
    input  logic        cmd_done,
    input  logic [31:0] cmd_result,
    output logic        busy,
    output logic        err,
    output logic        overrun
);

    localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [8:0] NUM_OPS_W = 9'(NUM_OPS);

    uart_cmd_state_t state_q, state_d;
    logic [7:0]      op_q, op_d;
    logic [31:0]     arg_q, arg_d;
    logic [1:0]      idx_q, idx_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [31:0]     result_q, result_d;
    logic            err_q, err_d;
    logic            ovr_q, ovr_d;
`ifdef UART_CMD_ECHO_EN
    logic            done_seen_q, done_seen_d;
`endif

    logic        ser_load;
    logic [31:0] ser_word;
    logic [7:0]  ser_tdata;
    logic        ser_tvalid;
    logic        ser_tlast;
    logic        ser_last_xfer;

    uart_word_ser u_ser (
        .clk      (clk),
        .Rst      (Rst),
        .load_i   (ser_load),
        .word_i   (ser_word),
        .tready_i (tx_ready),
        .tdata_o  (ser_tdata),
        .tvalid_o (ser_tvalid),
        .tlast_o  (ser_tlast)
    );

    assign ser_last_xfer = ser_tvalid && tx_ready && ser_tlast;

    // Next-state logic: the result word is handed to the serializer on the very
    // edge that samples cmd_done, so the first result byte appears one cycle later.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        arg_d    = arg_q;
        idx_d    = idx_q;
        tmo_d    = tmo_q;
        result_d = result_q;
        err_d    = 1'b0;
        ovr_d    = ovr_q;
        ser_load = 1'b0;
        ser_word = result_q;
`ifdef UART_CMD_ECHO_EN
        done_seen_d = done_seen_q;
`endif

        if (rx_valid && (state_q inside {ST_DISPATCH, ST_WAIT, ST_ECHO, ST_SEND, ST_NAK})) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if ({1'b0, rx_data} < NUM_OPS_W) begin
                        op_d    = rx_data;
                        idx_d   = 2'd0;
                        tmo_d   = '0;
                        state_d = ST_ARG;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_NAK;
                    end
                end
            end
            ST_ARG: begin
                if (rx_valid) begin
                    arg_d[{idx_q, 3'b000} +: 8] = rx_data;
                    idx_d = idx_q + 2'd1;
                    tmo_d = '0;
                    if (idx_q == 2'(ARG_BYTES - 1)) begin
                        state_d = ST_DISPATCH;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    arg_d   = 32'd0;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_DISPATCH: begin
`ifdef UART_CMD_ECHO_EN
                ser_load    = 1'b1;
                ser_word    = arg_q;
                done_seen_d = 1'b0;
                state_d     = ST_ECHO;
`else
                state_d = ST_WAIT;
`endif
            end
            ST_WAIT: begin
                if (cmd_done) begin
                    result_d = cmd_result;
                    ser_load = 1'b1;
                    ser_word = cmd_result;
                    state_d  = ST_SEND;
                end
            end
`ifdef UART_CMD_ECHO_EN
            ST_ECHO: begin
                if (cmd_done) begin
                    result_d    = cmd_result;
                    done_seen_d = 1'b1;
                end
                if (ser_last_xfer) begin
                    done_seen_d = 1'b0;
                    if (done_seen_q || cmd_done) begin
                        ser_load = 1'b1;
                        ser_word = cmd_done ? cmd_result : result_q;
                        state_d  = ST_SEND;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
`endif
            ST_SEND: begin
                if (ser_last_xfer) begin
                    state_d = ST_IDLE;
                end
            end
            ST_NAK: begin
                if (tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any command in flight.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= ST_IDLE;
            op_q     <= 8'd0;
            arg_q    <= 32'd0;
            idx_q    <= 2'd0;
            tmo_q    <= '0;
            result_q <= 32'd0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            arg_q    <= arg_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
            result_q <= result_d;
            err_q    <= err_d;
            ovr_q    <= ovr_d;
        end
    end

`ifdef UART_CMD_ECHO_EN
    // Remembers a result that arrived while the argument was still being echoed.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            done_seen_q <= 1'b0;
        end else begin
            done_seen_q <= done_seen_d;
        end
    end
`endif

    // Outputs: NAK owns the tx bus directly, otherwise the serializer drives it.
    always_comb begin
        tx_valid  = (state_q == ST_NAK) || ser_tvalid;
        tx_data   = (state_q == ST_NAK) ? NAK_BYTE : ser_tdata;
        cmd_start = (state_q == ST_DISPATCH);
        busy      = (state_q != ST_IDLE);
        cmd_op    = op_q;
        cmd_arg   = arg_q;
        err       = err_q;
        overrun   = ovr_q;
    end

endmodule

// File: doc/uart_cmd_seq.md
UART_CMD_SEQ -- requirements
Module: uart_cmd_seq

Interface
REQ-001 Parameter NUM_OPS, default 2: number of valid opcodes, 0..NUM_OPS-1.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: maximum idle gap between argument bytes, in clk cycles.
REQ-003 Parameter NAK_BYTE, default 8'hEE: byte returned when an opcode is rejected.
REQ-004 clk  input  1  system clock (clk_50M domain); all logic is on the rising edge.
REQ-005 Rst  input  1  reset, asynchronous, active-high.
REQ-006 rx_data  input  8  received UART byte; valid only while rx_valid is high.
REQ-007 rx_valid  input  1  one-cycle strobe, one per received byte.
REQ-008 tx_data  output  8  byte to transmit; stable while tx_valid is high.
REQ-009 tx_valid  output  1  transmit request; held until accepted.
REQ-010 tx_ready  input  1  UART transmitter can accept a byte; a transfer occurs when tx_valid and tx_ready are both high.
REQ-011 cmd_op  output  8  latched opcode for the core.
REQ-012 cmd_arg  output  32  latched little-endian argument.
REQ-013 cmd_start  output  1  one-cycle pulse starting the command.
REQ-014 cmd_done  input  1  one-cycle pulse from the core; cmd_result is valid in that cycle.
REQ-015 cmd_result  input  32  result word from the core.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 err  output  1  one-cycle pulse on a rejected opcode or an argument timeout.
REQ-018 overrun  output  1  sticky flag: a byte arrived while the block was not accepting bytes.

Function
REQ-019 The state machine SHALL have the states IDLE, ARG, DISPATCH, WAIT, ECHO, SEND and NAK.
REQ-020 IDLE, on rx_valid with rx_data < NUM_OPS: latch cmd_op, clear the byte index, clear the timeout counter, go to ARG.
REQ-021 IDLE, on rx_valid with rx_data >= NUM_OPS: pulse err, go to NAK.
REQ-022 NAK: present NAK_BYTE on tx_data with tx_valid high; on the transfer, go to IDLE.
REQ-023 ARG: each rx_valid stores rx_data into cmd_arg[8*idx+7:8*idx], increments idx and clears the timeout counter; after the 4th byte, go to DISPATCH.
REQ-024 ARG timeout: the counter increments each cycle without rx_valid; on reaching TIMEOUT_CYCLES, pulse err, discard the partial argument and go to IDLE.
REQ-025 DISPATCH: assert cmd_start for exactly one cycle, then go to ECHO if ECHO is compiled in, otherwise to WAIT.
REQ-026 WAIT: on cmd_done, latch cmd_result into the result register and go to SEND.
REQ-027 A cmd_done in any state other than WAIT and ECHO SHALL be ignored.
REQ-028 ECHO sub-rule: if cmd_done arrives during ECHO, latch the result and enter SEND directly after the echo completes.
REQ-029 SEND: transmit result bytes [7:0], [15:8], [23:16], [31:24] in that order, one byte per transfer; after the 4th transfer, go to IDLE.
REQ-030 tx_data and tx_valid SHALL NOT change while tx_valid is high and tx_ready is low.
REQ-031 Back-to-back transfers SHALL be supported: a new byte is presented in the cycle after a transfer.
REQ-032 rx_valid in DISPATCH, WAIT, ECHO, SEND or NAK: drop the byte and set overrun.
REQ-033 overrun SHALL clear only on Rst.
REQ-034 Latency: cmd_start SHALL be high in the cycle after the clock edge that samples the 4th argument byte.
REQ-035 Latency: tx_valid SHALL rise in the cycle after the edge that samples cmd_done in WAIT.
REQ-036 The block SHALL return to IDLE in the cycle after the final transfer and SHALL accept a new opcode byte in that IDLE cycle.

Reset
REQ-037 While Rst is high: state IDLE; tx_valid, cmd_start, err, busy and overrun 0; tx_data, cmd_op and cmd_arg 0; idx, timeout counter and result register 0.
REQ-038 Rst asserted mid-command SHALL abort the command immediately with no further tx transfers, and any pending cmd_done SHALL be ignored.

Configuration
REQ-039 Macro UART_CMD_ECHO_EN defined: DISPATCH goes to ECHO, which transmits cmd_arg bytes [7:0] to [31:24] before SEND, giving 8 tx bytes per valid command.
REQ-040 Macro UART_CMD_ECHO_EN undefined: no ECHO state or logic, DISPATCH goes to WAIT, and each valid command produces 4 tx bytes.

Structure
REQ-041 Package uart_cmd_pkg SHALL hold the state enum type uart_cmd_state_t, localparam ARG_BYTES = 4 and the default NAK_BYTE value.
REQ-042 One sub-module, uart_word_ser, SHALL implement the 32-bit-to-4-byte little-endian serializer with the valid/ready handshake; it is instantiated once and shared by ECHO and SEND.

Verification
REQ-043 Scenario: bytes 00, 00,01,00,00 -> cmd_op=0, cmd_arg=32'h100, one cmd_start; cmd_done with result 32'h1234ABCD -> tx CD,AB,34,12 (echo build: 00,01,00,00 first).
REQ-044 Scenario: byte 07 with NUM_OPS=2 -> err pulse, one tx byte EE, no cmd_start, return to IDLE.
REQ-045 Scenario: opcode 01, 2 argument bytes, then silence for TIMEOUT_CYCLES -> err pulse, IDLE, no cmd_start; the next full command executes normally.
REQ-046 Scenario: tx_ready held low for 100 cycles during SEND -> tx_data/tx_valid stable; release -> remaining bytes in order, none lost or duplicated.
REQ-047 Scenario: rx byte during WAIT -> overrun=1, command result still sent correctly.
REQ-048 Scenario: Rst pulse during SEND after 2 bytes -> all outputs at reset values, no further tx; a fresh command succeeds.
